// File: rtl/hp_bar_multi.sv
`default_nettype none
// ============================================================================
// Module   : hp_bar_multi
// Purpose  : Multi-channel HP tracker with edge-detected hits, saturating
//            damage, heal, frame-timed invulnerability, sticky death flag and
//            registered pixel-on flags for the filled and empty bar regions.
// Options  : HP_BAR_FLASH_EN - blink the filled bar every 4 frames while
//            invulnerable.
// Revision : 1.0 - initial release
// ============================================================================
module hp_bar_multi #(
  parameter int N_SRC       = 2,
  parameter int HP_MAX      = 150,
  parameter int DMG_PER_HIT = 30,
  parameter int HEAL_AMT    = 10,
  parameter int IFRAMES     = 30,
  parameter int BAR_X0      = 50,
  parameter int BAR_Y0      = 400,
  parameter int BAR_H       = 10,
  localparam int HPW        = $clog2(HP_MAX + 1)
) (
  input  logic             Pclk,
  input  logic             reset,
  input  logic [9:0]       xx,
  input  logic [9:0]       yy,
  input  logic             aactive,
  input  logic             frame_tick,
  input  logic [N_SRC-1:0] isCollision,
  input  logic             heal,
  output logic             hp_barOn,
  output logic             hp_bgOn,
  output logic [HPW-1:0]   hp,
  output logic             invuln,
  output logic             dead
);

  // Counter wide enough for IFRAMES; kept at 1 bit when the window is disabled.
  localparam int CW = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
  // Damage / heal arithmetic width: room for 8 simultaneous hits without wrap.
  localparam int DW = HPW + 4;

  localparam logic [1:0] ST_ALIVE  = 2'd0;
  localparam logic [1:0] ST_INVULN = 2'd1;
  localparam logic [1:0] ST_DEAD   = 2'd2;

  localparam logic [DW-1:0] HP_MAX_W = DW'(HP_MAX);
  localparam logic [DW-1:0] DMG_W    = DW'(DMG_PER_HIT);
  localparam logic [DW-1:0] HEAL_W   = DW'(HEAL_AMT);
  localparam logic [CW-1:0] IFR_LOAD = CW'(IFRAMES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Pixel bounds in 11 bits so BAR_X0 + HP_MAX beyond 1023 cannot wrap.
  localparam logic [10:0] X0_W   = 11'(BAR_X0);
  localparam logic [10:0] XEND_W = 11'(BAR_X0 + HP_MAX);
  localparam logic [10:0] Y0_W   = 11'(BAR_Y0);
  localparam logic [10:0] YEND_W = 11'(BAR_Y0 + BAR_H);

  logic [1:0]       state_q, state_d;
  logic [HPW-1:0]   hp_q, hp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_SRC-1:0] prev_q;
  logic             heal_prev_q;
  logic             invuln_q, dead_q;
  logic             bar_q, bar_d;
  logic             bg_q, bg_d;

  logic [N_SRC-1:0] new_hit;
  logic             heal_edge;
  logic [3:0]       hits_n;
  logic [DW-1:0]    dmg;
  logic [DW-1:0]    hp_w;
  logic [DW-1:0]    rem;
  logic [10:0]      x_w, y_w, fill_end;
  logic             in_row;

  assign new_hit   = isCollision & ~prev_q;
  assign heal_edge = heal & ~heal_prev_q;
  assign dmg       = DW'(hits_n) * DMG_W;
  assign hp_w      = DW'(hp_q);

  function automatic logic [DW-1:0] add_heal(input logic [DW-1:0] v);
    logic [DW-1:0] s;
    s = v + HEAL_W;
    return (s > HP_MAX_W) ? HP_MAX_W : s;
  endfunction

  // Count how many channels produced a fresh rising edge this cycle.
  always_comb begin
    hits_n = '0;
    for (int i = 0; i < N_SRC; i++) begin
      hits_n = hits_n + {3'b000, new_hit[i]};
    end
  end

  // Next HP / state: damage resolves before heal, death discards the heal.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    rem     = '0;
    case (state_q)
      ST_ALIVE: begin
        if (dmg != '0) begin
          if (dmg >= hp_w) begin
            hp_d    = '0;
            state_d = ST_DEAD;
          end else begin
            rem = hp_w - dmg;
            if (heal_edge) begin
              rem = add_heal(rem);
            end
            hp_d = rem[HPW-1:0];
            if (IFRAMES > 0) begin
              cnt_d   = IFR_LOAD;
              state_d = ST_INVULN;
            end
          end
        end else if (heal_edge) begin
          rem  = add_heal(hp_w);
          hp_d = rem[HPW-1:0];
        end
      end
      ST_INVULN: begin
        if (heal_edge) begin
          rem  = add_heal(hp_w);
          hp_d = rem[HPW-1:0];
        end
        if (frame_tick) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_ALIVE;
          end
        end
      end
      default: begin
        // Dead (or unreachable encoding): frozen until reset.
      end
    endcase
  end

`ifdef HP_BAR_FLASH_EN
  logic [3:0] frame_cnt_q;

  // Free-running frame counter that paces the invulnerability blink.
  always_ff @(posedge Pclk) begin
    if (reset) begin
      frame_cnt_q <= 4'd0;
    end else if (frame_tick) begin
      frame_cnt_q <= frame_cnt_q + 4'd1;
    end
  end
`endif

  // Bar geometry against the HP value held in the register this cycle.
  always_comb begin
    x_w      = {1'b0, xx};
    y_w      = {1'b0, yy};
    fill_end = X0_W + 11'(hp_q);
    in_row   = (y_w > Y0_W) && (y_w < YEND_W);
    bar_d    = aactive && in_row && (x_w > X0_W) && (x_w <= fill_end);
    bg_d     = aactive && in_row && (x_w > fill_end) && (x_w <= XEND_W);
`ifdef HP_BAR_FLASH_EN
    if (invuln_q && frame_cnt_q[2]) begin
      bar_d = 1'b0;
    end
`endif
  end

  // State, HP, edge history and registered outputs.
  always_ff @(posedge Pclk) begin
    if (reset) begin
      state_q     <= ST_ALIVE;
      hp_q        <= HPW'(HP_MAX);
      cnt_q       <= '0;
      prev_q      <= '0;
      heal_prev_q <= 1'b0;
      invuln_q    <= 1'b0;
      dead_q      <= 1'b0;
      bar_q       <= 1'b0;
      bg_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      cnt_q       <= cnt_d;
      prev_q      <= isCollision;
      heal_prev_q <= heal;
      invuln_q    <= (state_d == ST_INVULN);
      dead_q      <= (state_d == ST_DEAD);
      bar_q       <= bar_d;
      bg_q        <= bg_d;
    end
  end

  assign hp       = hp_q;
  assign invuln   = invuln_q;
  assign dead     = dead_q;
  assign hp_barOn = bar_q;
  assign hp_bgOn  = bg_q;

endmodule
`default_nettype wire

// File: tb/tb_hp_bar_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_hp_bar_multi
// Purpose  : Scoreboard bench for hp_bar_multi; a behavioural model predicts
//            HP, flags and pixel outputs for each driven cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hp_bar_multi;
  localparam int HP_MAX = 150;
  localparam int DMG    = 30;
  localparam int HEAL   = 10;
  localparam int IFR    = 30;
  localparam int X0     = 50;
  localparam int Y0     = 400;
  localparam int BH     = 10;
  localparam int HPW    = $clog2(HP_MAX + 1);

  logic           Pclk = 1'b0;
  logic           reset = 1'b1;
  logic [9:0]     xx = '0;
  logic [9:0]     yy = '0;
  logic           aactive = 1'b0;
  logic           frame_tick = 1'b0;
  logic [1:0]     isCollision = '0;
  logic           heal = 1'b0;
  logic           hp_barOn, hp_bgOn, invuln, dead;
  logic [HPW-1:0] hp;

  hp_bar_multi #(
    .N_SRC(2), .HP_MAX(HP_MAX), .DMG_PER_HIT(DMG), .HEAL_AMT(HEAL),
    .IFRAMES(IFR), .BAR_X0(X0), .BAR_Y0(Y0), .BAR_H(BH)
  ) dut (
    .Pclk(Pclk), .reset(reset), .xx(xx), .yy(yy), .aactive(aactive),
    .frame_tick(frame_tick), .isCollision(isCollision), .heal(heal),
    .hp_barOn(hp_barOn), .hp_bgOn(hp_bgOn), .hp(hp), .invuln(invuln),
    .dead(dead)
  );

  always #5 Pclk = ~Pclk;

  typedef struct {
    int hp;
    bit inv;
    bit dead;
    bit bar;
    bit bg;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int       m_hp = HP_MAX;
  int       m_inv_left = 0;
  bit       m_dead = 0;
  bit [1:0] m_prev = 0;
  bit       m_hprev = 0;
  int       m_fc = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input bit r, input logic [1:0] c, input bit h, input bit f,
                      input int x, input int y, input bit a);
    exp_t e;
    int   nh;
    int   dmg;
    bit   he;
    bit   row;
    @(negedge Pclk);
    reset = r; isCollision = c; heal = h; frame_tick = f;
    xx = 10'(x); yy = 10'(y); aactive = a;
    if (r) begin
      m_hp = HP_MAX; m_inv_left = 0; m_dead = 0; m_prev = 0; m_hprev = 0; m_fc = 0;
      e.bar = 0; e.bg = 0;
    end else begin
      row   = a && (y > Y0) && (y < Y0 + BH);
      e.bar = row && (x > X0) && (x <= X0 + m_hp);
      e.bg  = row && (x > X0 + m_hp) && (x <= X0 + HP_MAX);
`ifdef HP_BAR_FLASH_EN
      if (m_inv_left > 0 && ((m_fc / 4) % 2 == 1)) e.bar = 0;
      if (f) m_fc = (m_fc + 1) % 16;
`endif
      nh = $countones(c & ~m_prev);
      he = h && !m_hprev;
      if (m_dead) begin
        // frozen
      end else if (m_inv_left > 0) begin
        if (he) m_hp = (m_hp + HEAL > HP_MAX) ? HP_MAX : m_hp + HEAL;
        if (f) m_inv_left--;
      end else begin
        dmg = nh * DMG;
        if (dmg > 0 && dmg >= m_hp) begin
          m_hp = 0; m_dead = 1;
        end else begin
          m_hp = m_hp - dmg;
          if (he) m_hp = (m_hp + HEAL > HP_MAX) ? HP_MAX : m_hp + HEAL;
          if (dmg > 0 && IFR > 0) m_inv_left = IFR;
        end
      end
      m_prev  = c;
      m_hprev = h;
    end
    e.hp = m_hp; e.inv = (m_inv_left > 0); e.dead = m_dead;
    q.push_back(e);
  endtask

  task automatic tick(input bit r, input logic [1:0] c, input bit h, input bit f);
    step(r, c, h, f, int'($urandom_range(40, 215)), int'($urandom_range(398, 412)),
         ($urandom_range(0, 7) != 0));
  endtask

  task automatic frames(input int n, input logic [1:0] c);
    for (int i = 0; i < n; i++) begin
      tick(0, c, 0, 1);
      tick(0, c, 0, 0);
    end
  endtask

  // Monitor: compare every presented output cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge Pclk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hp",       int'(hp),       e.hp);
        chk("invuln",   int'(invuln),   int'(e.inv));
        chk("dead",     int'(dead),     int'(e.dead));
        chk("hp_barOn", int'(hp_barOn), int'(e.bar));
        chk("hp_bgOn",  int'(hp_bgOn),  int'(e.bg));
      end
    end
  end

  initial begin
    logic [1:0] c;
    bit         h;
    int         ys[3];
    ys[0] = 405; ys[1] = 400; ys[2] = 410;

    repeat (3) tick(1, 2'b00, 0, 0);
    // Full-health row scans, including the excluded edge rows
    for (int k = 0; k < 3; k++)
      for (int x = 0; x < 260; x++) step(0, 2'b00, 0, 0, x, ys[k], 1);
    step(0, 2'b00, 0, 0, 100, 405, 0);

    // Held collision counts once; window closes on the 30th frame tick
    repeat (100) tick(0, 2'b01, 0, 0);
    frames(IFR, 2'b01);
    for (int x = 160; x < 212; x++) step(0, 2'b01, 0, 0, x, 405, 1);
    tick(0, 2'b00, 0, 0);

    // Two channels rising together, then a channel-1 edge while invulnerable
    tick(1, 2'b00, 0, 0);
    tick(0, 2'b11, 0, 0);
    tick(0, 2'b00, 0, 0);
    tick(0, 2'b10, 0, 0);
    frames(IFR, 2'b00);

    // Clamp at full health, then repeated simultaneous hit+heal down to death
    tick(1, 2'b00, 0, 0);
    tick(0, 2'b00, 1, 0);
    tick(0, 2'b00, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tick(0, 2'b01, 1, 0);
      tick(0, 2'b00, 0, 0);
      frames(IFR, 2'b00);
    end
    for (int x = 40; x < 210; x += 7) step(0, 2'b00, 0, 0, x, 405, 1);
    tick(0, 2'b11, 1, 1);
    tick(0, 2'b00, 0, 0);

    // Reset in the middle of the invulnerability window with a held collision
    tick(1, 2'b00, 0, 0);
    tick(0, 2'b01, 0, 0);
    tick(0, 2'b01, 0, 1);
    tick(1, 2'b01, 0, 0);
    tick(0, 2'b01, 0, 0);
    tick(0, 2'b01, 0, 0);

    // Randomised traffic
    c = 2'b00; h = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) c[0] = ~c[0];
      if ($urandom_range(0, 7) == 0) c[1] = ~c[1];
      if ($urandom_range(0, 9) == 0) h = ~h;
      tick(($urandom_range(0, 299) == 0), c, h, ($urandom_range(0, 2) == 0));
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge Pclk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hp_bar_multi.md
Name: hp_bar_multi

Overview:
- Parametrised successor to the single-player HP bar.
- Tracks hit points against N_SRC collision channels: per-channel rising-edge hit detection, saturating damage, heal input, frame-timed invulnerability window and a death flag.
- Produces registered pixel-on flags for the filled and empty parts of the bar, consumed by the VGA colour mux alongside the other sprite layers.

Parameters:
- N_SRC, 2, number of collision input channels (1..8)
- HP_MAX, 150, full HP; bar length in pixels at full health (1..511)
- DMG_PER_HIT, 30, HP removed per accepted channel edge
- HEAL_AMT, 10, HP restored per accepted heal pulse
- IFRAMES, 30, invulnerability length in frame_tick pulses after accepted damage (0 = none)
- BAR_X0, 50, bar left edge; the first lit column is BAR_X0+1
- BAR_Y0, 400, bar top edge; lit rows are BAR_Y0+1 .. BAR_Y0+BAR_H-1
- BAR_H, 10, bar height bound

Ports:
- Pclk  in  1  25 MHz pixel clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- xx  in  10  current pixel x
- yy  in  10  current pixel y
- aactive  in  1  high during active pixel drawing
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- isCollision  in  N_SRC  per-channel collision level, held high while overlapping
- heal  in  1  heal request, level or pulse; rising edge only
- hp_barOn  out  1  pixel is inside the filled part of the bar
- hp_bgOn  out  1  pixel is inside the empty part of the bar
- hp  out  HPW  current HP, HPW = $clog2(HP_MAX+1)
- invuln  out  1  invulnerability window active
- dead  out  1  HP has reached 0; sticky until reset

Behaviour:
- Reset values:
  - hp = HP_MAX; hp_barOn = hp_bgOn = 0; invuln = 0; dead = 0.
  - Inverse counter = 0; edge-detect history registers = 0; state = ALIVE.
- Edge detect:
  - Per channel, new_hit[i] = isCollision[i] & ~prev[i]. prev updates every cycle in every state.
  - A held collision therefore counts once.
  - heal uses the same edge detect.
- Damage: dmg = popcount(new_hit) * DMG_PER_HIT, computed in HPW+4 bits (no overflow).
- FSM states:
  - ALIVE: any new_hit makes dmg nonzero.
    - If dmg >= hp: hp <= 0, go to DEAD.
    - Otherwise hp <= hp - dmg. If IFRAMES > 0, load the inverse counter with IFRAMES and go to INVULN.
  - INVULN: new_hit is ignored.
    - Counter decrements on each frame_tick.
    - On the frame_tick that takes the counter from 1 to 0, go to ALIVE.
    - Hits in that same cycle are still ignored.
  - DEAD: hits and heal are ignored; hp stays 0. Only reset leaves this state.
- Heal (ALIVE or INVULN only): hp <= min(hp + HEAL_AMT, HP_MAX).
- Simultaneous damage and heal in the same ALIVE cycle:
  - Damage is evaluated first. If it kills, heal is discarded.
  - Otherwise hp <= min(hp - dmg + HEAL_AMT, HP_MAX), and INVULN is entered as normal.
- Outputs: invuln = (state == INVULN); dead = (state == DEAD). Both are registered.
- Pixel path, registered with 1-cycle latency from xx/yy/aactive; uses the hp value held at that clock edge:
  - in_row = yy > BAR_Y0 && yy < BAR_Y0 + BAR_H.
  - hp_barOn = aactive && in_row && xx > BAR_X0 && xx <= BAR_X0 + hp.
  - hp_bgOn = aactive && in_row && xx > BAR_X0 + hp && xx <= BAR_X0 + HP_MAX.
  - hp_barOn and hp_bgOn are never both 1.
  - hp = 0 gives no filled pixels.
- Comparisons are done in 11 bits to avoid wrap when BAR_X0 + HP_MAX > 1023.
- Reset mid-INVULN or in DEAD: the next cycle is the full reset state. The edge-detect history is cleared, so a collision held high across reset registers as a new hit on the first cycle after reset.

Optional Feature:
- Macro: HP_BAR_FLASH_EN.
- Defined:
  - A 4-bit free-running frame counter increments on frame_tick and resets to 0.
  - While invuln = 1 and counter bit 2 = 1, hp_barOn is forced to 0. The filled region also shows as neither on nor bg.
  - Result: the bar blinks every 4 frames.
- Undefined: no counter; the bar is drawn steady during INVULN.

Test Plan:
- Reset, then scan row yy = 405 with aactive = 1 -> hp = 150; hp_barOn = 1 for xx 51..200; hp_bgOn = 0 everywhere; both 0 at yy = 400 and 410; outputs appear one cycle after inputs.
- isCollision[0] held high for 100 cycles from ALIVE -> hp = 120 once; invuln = 1. Apply 30 frame_tick pulses -> invuln falls on the 30th. Held level causes no further damage. hp_bgOn = 1 for xx 171..200.
- isCollision = 2'b11 rising in the same cycle -> hp 150 -> 90 (60 damage); a channel-1 edge during INVULN leaves hp = 90.
- hp = 20, then a channel-0 edge -> hp = 0, dead = 1, no bar pixels. Later heal and hit edges change nothing until reset.
- hp = 145 plus heal edge -> 150 (clamped). hp = 100 with simultaneous hit and heal -> 80. hp = 30 with simultaneous hit and heal -> dead.
- Reset asserted mid-INVULN while isCollision[0] is held -> hp = 150, invuln = 0 after reset; a hit is counted on the first post-reset cycle, giving hp = 120.
- With HP_BAR_FLASH_EN defined, INVULN blanks hp_barOn on frames 4-7, 12-15 of the counter.
